// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives the instruction ROM address, holds one
// fetched word for decode over a valid/ready handshake, and applies branches and halt.
module fetch_sequencer #(
    parameter int IW = 16,
    parameter int DW = 9,
    parameter int OW = 8
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    output logic [IW-1:0] InstAddress,
    input  logic [DW-1:0] InstIn,
    output logic [DW-1:0] Inst,
    output logic [IW-1:0] InstPC,
    output logic          InstValid,
    input  logic          InstReady,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [IW-1:0] BranchTarget,
    input  logic [OW-1:0] BranchOff,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] pc_q;
    logic [DW-1:0] inst_q;
    logic [IW-1:0] inst_pc_q;
    logic          valid_q;

    logic          xfer;
    logic [IW-1:0] pc_inc;
    logic [IW-1:0] branch_d;

    function automatic logic [IW-1:0] sext_off(input logic [OW-1:0] off);
        logic signed [OW-1:0] s;
        logic signed [IW-1:0] e;
        s = off;
        e = IW'(s);
        return e;
    endfunction

    assign xfer     = valid_q & InstReady;
    assign pc_inc   = pc_q + IW'(1);
    // Relative branches are taken from the address of the accepted instruction, not the PC.
    assign branch_d = BranchAbs ? BranchTarget : inst_pc_q + sext_off(BranchOff);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (Start) begin
                        pc_q    <= StartAddr;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    inst_q    <= InstIn;
                    inst_pc_q <= pc_q;
                    pc_q      <= pc_inc;
                    valid_q   <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    if (xfer) begin
                        if (Halt) begin
                            valid_q <= 1'b0;
                            state_q <= DONE;
                        end else if (BranchEn) begin
                            pc_q    <= branch_d;
                            valid_q <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            inst_q    <= InstIn;
                            inst_pc_q <= pc_q;
                            pc_q      <= pc_inc;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InstAddress = pc_q;
    assign Inst        = inst_q;
    assign InstPC      = inst_pc_q;
    assign InstValid   = valid_q;
    assign Busy        = (state_q == FETCH) || (state_q == ISSUE);
    assign Done        = (state_q == DONE);

endmodule
